// File: rtl/pc_update_unit.sv
// Program-counter stage: PC, EPC and cause registers, branch-qualified
// PC writes, and the exception-vector fetch sequence.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE  = 32'd255,
  parameter logic [31:0] VEC_OVF     = 32'd254,
  parameter logic [31:0] VEC_DIV     = 32'd253,
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_source_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  exc_mem_data,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [1:0]  cause_out,
  output logic [31:0] exc_mem_addr,
  output logic        exc_mem_rd,
  output logic        exc_busy
);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_EXC_READ,
    S_EXC_WAIT
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [1:0]  r_cause;
  logic [2:0]  r_cnt;
  logic        w_cond;
  logic        w_take;
  logic        w_vec_load;
  logic        w_pc_we;
  logic        w_busy;
  logic [31:0] w_vec_addr;

  always_comb begin
    w_cond = 1'b0;
    unique case (branch_type)
      2'd0: w_cond = alu_zero;
      2'd1: w_cond = !alu_zero;
      2'd2: w_cond = alu_zero | alu_neg;
      2'd3: w_cond = !alu_zero & !alu_neg;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_vec_load = 1'b0;
    unique case (r_state)
      S_NORMAL: begin
        if (exc_req) begin
          w_take = 1'b1;
          w_next = S_EXC_READ;
        end
      end
      S_EXC_READ: w_next = S_EXC_WAIT;
      S_EXC_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_vec_load = 1'b1;
          w_next     = S_NORMAL;
        end
      end
      default: w_next = S_NORMAL;
    endcase
  end

  // exception acceptance beats any PC write in the same cycle
  assign w_pc_we = (r_state == S_NORMAL) & !exc_req &
                   (pc_write | (pc_write_cond & w_cond));

  always_comb begin
    w_vec_addr = VEC_OPCODE;
    unique case (r_cause)
      2'd1:    w_vec_addr = VEC_OVF;
      2'd2:    w_vec_addr = VEC_DIV;
      default: w_vec_addr = VEC_OPCODE;
    endcase
  end

  assign w_busy       = (r_state != S_NORMAL);
  assign exc_busy     = w_busy;
  assign exc_mem_rd   = w_busy;
  assign exc_mem_addr = w_busy ? w_vec_addr : 32'd0;
  assign pc_out       = r_pc;
  assign epc_out      = r_epc;
  assign cause_out    = r_cause;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_NORMAL;
      r_pc    <= RESET_PC;
      r_epc   <= 32'd0;
      r_cause <= 2'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_cause <= exc_code;
        r_epc   <= r_pc - EPC_OFFSET;
      end
      if (w_vec_load) begin
        r_pc <= {24'b0, exc_mem_data};
      end else if (w_pc_we) begin
        r_pc <= pc_source_in;
      end
      if (r_state == S_EXC_READ) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == S_EXC_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: two instances (latency 1 and 3) driven in
// lockstep and compared against a countdown-based reference model.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_source_in;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_neg;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [7:0]  exc_mem_data;

  logic [31:0] pc_o   [2];
  logic [31:0] epc_o  [2];
  logic [1:0]  cause_o[2];
  logic [31:0] addr_o [2];
  logic        rd_o   [2];
  logic        busy_o [2];

  int total = 0;
  int bad   = 0;

  int          lat  [2] = '{1, 3};
  logic [31:0] m_pc [2];
  logic [31:0] m_epc[2];
  logic [1:0]  m_cause[2];
  int          m_left[2];

  always #5 clk = ~clk;

  pc_update_unit #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .pc_source_in(pc_source_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_type(branch_type), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .exc_req(exc_req), .exc_code(exc_code), .exc_mem_data(exc_mem_data),
    .pc_out(pc_o[0]), .epc_out(epc_o[0]), .cause_out(cause_o[0]),
    .exc_mem_addr(addr_o[0]), .exc_mem_rd(rd_o[0]), .exc_busy(busy_o[0])
  );

  pc_update_unit #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .pc_source_in(pc_source_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_type(branch_type), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .exc_req(exc_req), .exc_code(exc_code), .exc_mem_data(exc_mem_data),
    .pc_out(pc_o[1]), .epc_out(epc_o[1]), .cause_out(cause_o[1]),
    .exc_mem_addr(addr_o[1]), .exc_mem_rd(rd_o[1]), .exc_busy(busy_o[1])
  );

  function automatic logic taken(input logic [1:0] bt, input logic z,
                                 input logic n);
    case (bt)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return z || n;
      default: return !z && !n;
    endcase
  endfunction

  function automatic logic [31:0] vec(input logic [1:0] c);
    if (c == 2'd1) return 32'd254;
    if (c == 2'd2) return 32'd253;
    return 32'd255;
  endfunction

  // One clock edge of the reference: busy is a countdown of remaining
  // exception cycles rather than an explicit state.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = 32'h0; m_epc[k] = 32'h0;
        m_cause[k] = 2'd0; m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_pc[k] = {24'h0, exc_mem_data};
      end else if (exc_req) begin
        m_cause[k] = exc_code;
        m_epc[k]   = m_pc[k] - 32'd4;
        m_left[k]  = lat[k] + 1;
      end else if (pc_write ||
                   (pc_write_cond && taken(branch_type, alu_zero, alu_neg))) begin
        m_pc[k] = pc_source_in;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic bsy;
      bsy = (m_left[k] > 0);
      chk($sformatf("pc[%0d]", k),    pc_o[k],          m_pc[k]);
      chk($sformatf("epc[%0d]", k),   epc_o[k],         m_epc[k]);
      chk($sformatf("cause[%0d]", k), 32'(cause_o[k]),  32'(m_cause[k]));
      chk($sformatf("busy[%0d]", k),  32'(busy_o[k]),   32'(bsy));
      chk($sformatf("rd[%0d]", k),    32'(rd_o[k]),     32'(bsy));
      chk($sformatf("addr[%0d]", k),  addr_o[k],
          bsy ? vec(m_cause[k]) : 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; exc_req = 0;
  endtask

  initial begin
    reset = 1; pc_source_in = 32'h40; pc_write = 1; pc_write_cond = 0;
    branch_type = 0; alu_zero = 0; alu_neg = 0;
    exc_req = 0; exc_code = 0; exc_mem_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 'x; m_epc[k] = 'x; m_cause[k] = 'x; m_left[k] = 0;
    end
    #2;
    // reset held over three edges with a pending write
    repeat (3) tick();
    chk("rst_pc_const", pc_o[0], 32'h0);
    reset = 0;

    pc_source_in = 32'h4; tick();
    chk("wr4_const", pc_o[0], 32'h4);
    pc_source_in = 32'h8; tick();
    chk("wr8_const", pc_o[1], 32'h8);
    idle_inputs();

    pc_write_cond = 1; pc_source_in = 32'h100;
    branch_type = 0; alu_zero = 1; alu_neg = 0; tick();
    chk("beq_taken_const", pc_o[0], 32'h100);
    pc_write = 1; pc_source_in = 32'h8; pc_write_cond = 0; tick();
    pc_write = 0; pc_write_cond = 1; pc_source_in = 32'h100;
    branch_type = 0; alu_zero = 0; tick();
    chk("beq_not_const", pc_o[0], 32'h8);
    branch_type = 2; alu_neg = 1; tick();
    chk("blez_const", pc_o[0], 32'h100);
    pc_source_in = 32'h200; branch_type = 3; alu_neg = 1; tick();
    chk("bgtz_neg_const", pc_o[0], 32'h100);
    alu_neg = 0; alu_zero = 0; tick();
    chk("bgtz_pos_const", pc_o[0], 32'h200);
    idle_inputs();

    pc_write = 1; pc_source_in = 32'h20; tick();
    // exception with a simultaneous pc_write that must be dropped
    exc_req = 1; exc_code = 1; pc_write = 1; pc_source_in = 32'h55;
    exc_mem_data = 8'h7C; tick();
    chk("epc_1c_const", epc_o[0], 32'h1C);
    exc_req = 1; exc_code = 2; pc_write = 1; pc_source_in = 32'h99; tick();
    idle_inputs();
    repeat (4) tick();
    chk("vec_pc_l1_const", pc_o[0], 32'h7C);
    chk("vec_pc_l3_const", pc_o[1], 32'h7C);
    chk("cause_hold_const", 32'(cause_o[1]), 32'd1);

    // reset while both instances sit in the wait state
    exc_req = 1; exc_code = 0; tick();
    idle_inputs(); tick();
    reset = 1; tick();
    reset = 0;
    exc_req = 1; exc_code = 2; tick();
    chk("epc_wrap_const", epc_o[1], 32'hFFFF_FFFC);
    idle_inputs();
    repeat (5) tick();

    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      exc_req       = ($urandom_range(0, 11) == 0);
      exc_code      = 2'($urandom);
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = 1'($urandom);
      branch_type   = 2'($urandom);
      alu_zero      = 1'($urandom);
      alu_neg       = 1'($urandom);
      pc_source_in  = $urandom;
      exc_mem_data  = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
